// File: rtl/clock_display_scanner.sv
// Scans sec/min/hour onto a 6-digit multiplexed 7-segment display (HH.MM.SS).
// Optional feature: define CLOCK_DISP_LZB_EN to blank a leading zero in the hour tens digit.
module clock_display_scanner #(
    parameter int P_SCAN_DIV = 1000,
    parameter int P_SCAN_BIT = 10,
    parameter int P_SEC_BIT  = 6,
    parameter int P_MIN_BIT  = 6,
    parameter int P_HOUR_BIT = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_en,
    input  logic [P_SEC_BIT-1:0]  i_sec,
    input  logic [P_MIN_BIT-1:0]  i_min,
    input  logic [P_HOUR_BIT-1:0] i_hour,
    output logic [5:0]            o_digit_sel,
    output logic [6:0]            o_seg,
    output logic                  o_dp,
    output logic                  o_frame_tick
);

    localparam logic [P_SCAN_BIT-1:0] DIV_LAST = P_SCAN_BIT'(P_SCAN_DIV - 1);
    localparam logic [2:0]            IDX_LAST = 3'd5;

    // Tens digit saturates at 6, so values 60..63 read literally as "6x".
    function automatic logic [7:0] bcd_split(input logic [7:0] v);
        if (v >= 8'd60) return {4'd6, 4'(v - 8'd60)};
        if (v >= 8'd50) return {4'd5, 4'(v - 8'd50)};
        if (v >= 8'd40) return {4'd4, 4'(v - 8'd40)};
        if (v >= 8'd30) return {4'd3, 4'(v - 8'd30)};
        if (v >= 8'd20) return {4'd2, 4'(v - 8'd20)};
        if (v >= 8'd10) return {4'd1, 4'(v - 8'd10)};
        return {4'd0, v[3:0]};
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    logic [P_SCAN_BIT-1:0] div_p0;
    logic [2:0]            idx_p0;
    logic [P_SEC_BIT-1:0]  snap_sec_p0;
    logic [P_MIN_BIT-1:0]  snap_min_p0;
    logic [P_HOUR_BIT-1:0] snap_hour_p0;
    logic                  frame_pend_p0;

    logic scan_tick;
    logic frame_end;

    assign scan_tick = i_en && (div_p0 == DIV_LAST);
    assign frame_end = scan_tick && (idx_p0 == IDX_LAST);

    // Stage p0: scan divider, digit index and per-frame time snapshot
    always_ff @(posedge clk) begin
        if (reset) begin
            div_p0        <= '0;
            idx_p0        <= '0;
            snap_sec_p0   <= '0;
            snap_min_p0   <= '0;
            snap_hour_p0  <= '0;
            frame_pend_p0 <= 1'b0;
        end else if (!i_en) begin
            div_p0        <= '0;
            idx_p0        <= '0;
            snap_sec_p0   <= i_sec;
            snap_min_p0   <= i_min;
            snap_hour_p0  <= i_hour;
            frame_pend_p0 <= 1'b0;
        end else begin
            frame_pend_p0 <= frame_end;
            if (scan_tick) begin
                div_p0 <= '0;
                idx_p0 <= (idx_p0 == IDX_LAST) ? 3'd0 : idx_p0 + 3'd1;
            end else begin
                div_p0 <= div_p0 + P_SCAN_BIT'(1);
            end
            if (frame_end) begin
                snap_sec_p0  <= i_sec;
                snap_min_p0  <= i_min;
                snap_hour_p0 <= i_hour;
            end
        end
    end

    logic [7:0] field_p0;
    logic [7:0] bcd_p0;
    logic [3:0] nibble_p0;
    logic       blank_p0;

    always_comb begin
        field_p0  = '0;
        bcd_p0    = '0;
        nibble_p0 = '0;
        blank_p0  = 1'b0;
        case (idx_p0)
            3'd0, 3'd1: field_p0 = 8'(snap_sec_p0);
            3'd2, 3'd3: field_p0 = 8'(snap_min_p0);
            default:    field_p0 = 8'(snap_hour_p0);
        endcase
        bcd_p0    = bcd_split(field_p0);
        // Odd slots carry the tens digit of their field.
        nibble_p0 = idx_p0[0] ? bcd_p0[7:4] : bcd_p0[3:0];
`ifdef CLOCK_DISP_LZB_EN
        blank_p0  = (idx_p0 == IDX_LAST) && (bcd_p0[7:4] == 4'd0);
`else
        blank_p0  = 1'b0;
`endif
    end

    // Stage p1: registered display outputs; the frame tick is delayed one
    // cycle so it lines up with digit 0 of the new frame on the pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_digit_sel  <= '0;
            o_seg        <= '0;
            o_dp         <= 1'b0;
            o_frame_tick <= 1'b0;
        end else begin
            o_digit_sel  <= i_en ? (6'b000001 << idx_p0) : 6'b000000;
            o_seg        <= (i_en && !blank_p0) ? glyph(nibble_p0) : 7'h00;
            o_dp         <= i_en && ((idx_p0 == 3'd2) || (idx_p0 == 3'd4));
            o_frame_tick <= i_en && frame_pend_p0;
        end
    end

endmodule
